// File: rtl/debug_dump_tx.sv
// ---------------------------------------------------------------------------
// debug_dump_tx
//
// When start is accepted, this block streams a snapshot of the pipeline over
// a UART 8N1 line. The frame is the header byte 0xA5, then the PC, then
// registers 0..31, then data-memory words 0..MEM_WORDS-1. Every 32-bit word
// is sent MSB byte first. The pipeline keeps running. Register and memory
// values are sampled at the moment each word is fetched.
//
// Ports
//   clk           sole clock, rising edge
//   rst_n         asynchronous active-low reset
//   start         dump request, honoured only while idle
//   pc_value      PC, latched when start is accepted
//   reg_sel       register index for the register-file debug mux
//   reg_data      combinational register contents for reg_sel
//   debugMode     hands the data memory to the debug port during a dump
//   DebugAddress  data-memory word address
//   debugClk      data-memory debug read clock (one-cycle pulse per word)
//   mem_data      data-memory read word, valid after debugClk rises
//   tx            UART line, idle high
//   busy          high from accepted start until the done cycle
//   done          one-cycle pulse after the final stop bit
// ---------------------------------------------------------------------------
module debug_dump_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned MEM_WORDS    = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] pc_value,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        debugMode,
    output logic [31:0] DebugAddress,
    output logic        debugClk,
    input  logic [31:0] mem_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  MEM_LAST  = IDX_W'(MEM_WORDS - 1);
    localparam logic [7:0]        HEADER    = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        PC,
        REG_FETCH,
        MEM_ADDR,
        MEM_CLK,
        MEM_CAP,
        SEND,
        FINISH
    } state_t;

    // Which part of the frame the word in word_q belongs to.
    typedef enum logic [1:0] {
        SEC_HDR,
        SEC_PC,
        SEC_REG,
        SEC_MEM
    } sec_t;

    typedef enum logic [1:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP
    } ustate_t;

    // Top FSM registers
    state_t             state_q, state_d;
    sec_t               sec_q, sec_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        word_q, word_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [4:0]         reg_idx_q, reg_idx_d;
    logic [IDX_W-1:0]   mem_idx_q, mem_idx_d;
    logic [31:0]        addr_q, addr_d;
    logic               dclk_q, dclk_d;

    // UART sub-FSM registers
    ustate_t            ustate_q, ustate_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         ubyte_q, ubyte_d;
    logic               tx_q, tx_d;

    // Handshake between the two FSMs
    logic               uart_load;
    logic [7:0]         uart_byte;
    logic               uart_done;
    logic               bit_end;

    assign bit_end   = (baud_q == BAUD_LAST);
    assign uart_done = (ustate_q == U_STOP) && bit_end;

    // ------------------------------------------------------------------
    // Top FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sec_q      <= SEC_HDR;
            pc_q       <= '0;
            word_q     <= '0;
            byte_idx_q <= '0;
            reg_idx_q  <= '0;
            mem_idx_q  <= '0;
            addr_q     <= '0;
            dclk_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sec_q      <= sec_d;
            pc_q       <= pc_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            reg_idx_q  <= reg_idx_d;
            mem_idx_q  <= mem_idx_d;
            addr_q     <= addr_d;
            dclk_q     <= dclk_d;
        end
    end

    // The fetch states hand the MSB byte straight to the UART in the same
    // cycle they capture the word. This keeps the idle gap per word at one
    // cycle for registers and three for memory words.
    always_comb begin
        state_d    = state_q;
        sec_d      = sec_q;
        pc_d       = pc_q;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        reg_idx_d  = reg_idx_q;
        mem_idx_d  = mem_idx_q;
        addr_d     = addr_q;
        uart_load  = 1'b0;
        uart_byte  = 8'h00;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SEND;
                    sec_d      = SEC_HDR;
                    pc_d       = pc_value;
                    byte_idx_d = '0;
                    reg_idx_d  = '0;
                    mem_idx_d  = '0;
                    uart_load  = 1'b1;
                    uart_byte  = HEADER;
                end
            end
            PC: begin
                word_d     = pc_q;
                byte_idx_d = '0;
                uart_load  = 1'b1;
                uart_byte  = pc_q[31:24];
                state_d    = SEND;
            end
            REG_FETCH: begin
                word_d     = reg_data;
                byte_idx_d = '0;
                uart_load  = 1'b1;
                uart_byte  = reg_data[31:24];
                state_d    = SEND;
            end
            MEM_ADDR: begin
                addr_d  = 32'(mem_idx_q);
                state_d = MEM_CLK;
            end
            MEM_CLK: begin
                state_d = MEM_CAP;
            end
            MEM_CAP: begin
                word_d     = mem_data;
                byte_idx_d = '0;
                uart_load  = 1'b1;
                uart_byte  = mem_data[31:24];
                state_d    = SEND;
            end
            SEND: begin
                if (uart_done) begin
                    if (sec_q == SEC_HDR) begin
                        sec_d   = SEC_PC;
                        state_d = PC;
                    end else if (byte_idx_q != 2'd3) begin
                        // Chain the next byte of this word with no idle gap.
                        byte_idx_d = 2'(byte_idx_q + 2'd1);
                        uart_load  = 1'b1;
                        case (byte_idx_d)
                            2'd1:    uart_byte = word_q[23:16];
                            2'd2:    uart_byte = word_q[15:8];
                            default: uart_byte = word_q[7:0];
                        endcase
                    end else begin
                        case (sec_q)
                            SEC_PC: begin
                                sec_d     = SEC_REG;
                                reg_idx_d = '0;
                                state_d   = REG_FETCH;
                            end
                            SEC_REG: begin
                                if (reg_idx_q == 5'd31) begin
                                    sec_d     = SEC_MEM;
                                    mem_idx_d = '0;
                                    state_d   = MEM_ADDR;
                                end else begin
                                    reg_idx_d = 5'(reg_idx_q + 5'd1);
                                    state_d   = REG_FETCH;
                                end
                            end
                            SEC_MEM: begin
                                if (mem_idx_q == MEM_LAST) begin
                                    state_d = FINISH;
                                end else begin
                                    mem_idx_d = IDX_W'(mem_idx_q + 1'b1);
                                    state_d   = MEM_ADDR;
                                end
                            end
                            default: state_d = FINISH;
                        endcase
                    end
                end
            end
            FINISH: begin
                byte_idx_d = '0;
                reg_idx_d  = '0;
                mem_idx_d  = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // debugClk is registered so the memory sees a clean, glitch-free pulse
    // that is high exactly while the FSM sits in MEM_CLK.
    assign dclk_d = (state_d == MEM_CLK);

    // ------------------------------------------------------------------
    // UART 8N1 sub-FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ustate_q <= U_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            ubyte_q  <= '0;
            tx_q     <= 1'b1;
        end else begin
            ustate_q <= ustate_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            ubyte_q  <= ubyte_d;
            tx_q     <= tx_d;
        end
    end

    always_comb begin
        ustate_d = ustate_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        ubyte_d  = ubyte_q;

        case (ustate_q)
            U_IDLE: begin
                if (uart_load) begin
                    ustate_d = U_START;
                    baud_d   = '0;
                    bit_d    = '0;
                    ubyte_d  = uart_byte;
                end
            end
            U_START: begin
                if (bit_end) begin
                    baud_d   = '0;
                    bit_d    = '0;
                    ustate_d = U_DATA;
                end else begin
                    baud_d = BAUD_W'(baud_q + 1'b1);
                end
            end
            U_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d    = '0;
                        ustate_d = U_STOP;
                    end else begin
                        bit_d = 3'(bit_q + 3'd1);
                    end
                end else begin
                    baud_d = BAUD_W'(baud_q + 1'b1);
                end
            end
            U_STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (uart_load) begin
                        ustate_d = U_START;
                        ubyte_d  = uart_byte;
                    end else begin
                        ustate_d = U_IDLE;
                    end
                end else begin
                    baud_d = BAUD_W'(baud_q + 1'b1);
                end
            end
            default: ustate_d = U_IDLE;
        endcase
    end

    // tx is registered from the next UART state so the line never glitches.
    always_comb begin
        case (ustate_d)
            U_START: tx_d = 1'b0;
            U_DATA:  tx_d = ubyte_d[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy         = (state_q != IDLE) && (state_q != FINISH);
    assign debugMode    = busy;
    assign done         = (state_q == FINISH);
    assign reg_sel      = reg_idx_q;
    assign DebugAddress = addr_q;
    assign debugClk     = dclk_q;
    assign tx           = tx_q;

endmodule

// File: doc/debug_dump_tx.md
DEBUG_DUMP_TX -- requirements
Module: debug_dump_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868: clock cycles per UART bit (100 MHz / 115200).
REQ-002 Parameter MEM_WORDS, default 32: data-memory words dumped per frame (1..256).
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  dump request, sampled each cycle.
REQ-006 pc_value  in  32  pipeline PC, sampled on accepted start.
REQ-007 reg_sel  out  5  register index to pipeline register-file debug mux.
REQ-008 reg_data  in  32  combinational register contents for reg_sel.
REQ-009 debugMode  out  1  gives data memory to debug port.
REQ-010 DebugAddress  out  32  data-memory word address.
REQ-011 debugClk  out  1  data-memory debug read clock.
REQ-012 mem_data  in  32  data-memory read word, valid after debugClk rising edge.
REQ-013 tx  out  1  UART 8N1 line, idle high.
REQ-014 busy  out  1  high from accepted start until done.
REQ-015 done  out  1  one-cycle pulse after final stop bit.

Function
REQ-016 Frame byte order: header 0xA5; PC; reg0..reg31; mem word 0..MEM_WORDS-1; every 32-bit word sent MSB byte first; total 133+4*MEM_WORDS bytes.
REQ-017 Top FSM states: IDLE, PC, REG_FETCH, MEM_ADDR, MEM_CLK, MEM_CAP, SEND, FINISH.
REQ-018 IDLE: start=1 accepted only in IDLE with busy=0; next cycle busy=1, debugMode=1, pc_value latched, header byte queued.
REQ-019 start while busy or during done pulse is ignored, not queued.
REQ-020 REG_FETCH: reg_sel driven one full cycle before reg_data captured into 32-bit shift word.
REQ-021 MEM_ADDR drives DebugAddress=word index; MEM_CLK drives debugClk=1 one cycle; MEM_CAP drives debugClk=0 and captures mem_data.
REQ-022 debugClk is low in every state other than MEM_CLK; DebugAddress holds last value between reads.
REQ-023 SEND hands one byte to UART sub-FSM and waits for its completion before next byte or next fetch.
REQ-024 UART sub-FSM: START (tx=0), DATA (8 bits LSB first), STOP (tx=1); each bit exactly CLKS_PER_BIT cycles; no idle gap required between bytes.
REQ-025 Bit counter 0..7 and baud counter 0..CLKS_PER_BIT-1 wrap to 0 at end of each bit/byte.
REQ-026 Register index 0..31 and memory index 0..MEM_WORDS-1 advance after 4th byte of each word; after last memory word go to FINISH.
REQ-027 FINISH: done=1 one cycle, busy=0, debugMode=0, next state IDLE; start in that same cycle ignored.
REQ-028 Latency start accepted -> done = (133+4*MEM_WORDS)*10*CLKS_PER_BIT plus fetch overhead; overhead is at most 3 cycles per word.
REQ-029 Frame contents reflect register/memory values at fetch time; pipeline is not stalled by this block.

Reset
REQ-030 rst_n=0 at any time, including mid-byte: immediately tx=1, busy=0, done=0, debugMode=0, debugClk=0, reg_sel=0, DebugAddress=0, all counters 0, state IDLE.
REQ-031 After rst_n deasserts, no byte resumes; next frame requires a new start.

Verification
REQ-032 CLKS_PER_BIT=4, MEM_WORDS=1, pc_value=0x00000010, reg_k=k, mem0=0xDEADBEEF; start 1 cycle -> 137 bytes: A5, 00 00 00 10, 00 00 00 00 ... 00 00 00 1F, DE AD BE EF; then done pulse.
REQ-033 Bit timing: header 0xA5 -> tx low 4 cycles, bits 1,0,1,0,0,1,0,1 each 4 cycles, high 4 cycles.
REQ-034 start pulsed again mid-frame and during done cycle -> no second frame, byte count stays 137.
REQ-035 rst_n low during 10th byte -> tx=1, busy=0, debugMode=0 same cycle; no further bytes until new start.
REQ-036 MEM_WORDS=3 -> DebugAddress sequence 0,1,2; exactly 3 debugClk one-cycle pulses per frame; debugClk low otherwise.
REQ-037 Back-to-back start asserted right after done -> second frame identical to first, beginning with header 0xA5.
